range_tracker_multi: RTL and testbench

- Multi-channel successor to the single-channel range finder.
- Tracks per-channel minimum, maximum, range and sample count over a go/finish measurement window, in signed or unsigned mode.
- Publishes registered results with a one-cycle done pulse and an encoded error status.
- Sits between the sample front-end and the result readout / debug logic.

---
 rtl/range_tracker_pkg.sv | 11 +
 rtl/range_tracker_multi_if.sv | 29 ++
 rtl/range_channel.sv | 48 ++++
 rtl/range_tracker_multi.sv | 85 ++++++++
 tb/tb_range_tracker_multi.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/range_tracker_pkg.sv
// range_tracker_pkg: shared FSM/error types and the mode-aware compare helper
// Imported by range_channel and range_tracker_multi.
package range_tracker_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_GO_FINISH, ERR_FINISH_IDLE, ERR_EMPTY} err_t;
  // a < b from the operand MSBs and the unsigned result; in signed mode
  // differing MSBs alone decide, the negative operand being the smaller
  function automatic logic less_than(input logic sgn, input logic a_msb, input logic b_msb, input logic ult);
    return (sgn && a_msb != b_msb) ? a_msb : ult;
  endfunction
endpackage

// File: rtl/range_tracker_multi_if.sv
// range_tracker_multi_if: sample/control/result bundle of the range tracker
// master drives samples and go/finish and reads results; slave is the tracker.
interface range_tracker_multi_if #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 4,
  parameter int CNT_WIDTH = 8
);
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0] data_valid;
  logic signed_mode;
  logic go;
  logic finish;
  logic busy;
  logic done;
  logic [CHANNELS*WIDTH-1:0] min_out;
  logic [CHANNELS*WIDTH-1:0] max_out;
  logic [CHANNELS*WIDTH-1:0] range_out;
  logic [CHANNELS*CNT_WIDTH-1:0] count_out;
  logic [CHANNELS-1:0] count_sat;
  logic [1:0] err_code;
  modport master (
    output data_in, data_valid, signed_mode, go, finish,
    input busy, done, min_out, max_out, range_out, count_out, count_sat, err_code
  );
  modport slave (
    input data_in, data_valid, signed_mode, go, finish,
    output busy, done, min_out, max_out, range_out, count_out, count_sat, err_code
  );
endinterface

// File: rtl/range_channel.sv
// range_channel: working min/max/count/saturation for one channel
// Ports: clock, reset_n (async low); clear starts a fresh window this cycle,
// accept takes sample this cycle, signed_mode selects the compare.
// Outputs are the post-edge (next) working stats so the top can latch a
// sample arriving on the closing cycle together with the update.
module range_channel #(
  parameter int WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic accept,
  input  logic signed_mode,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] min_nx,
  output logic [WIDTH-1:0] max_nx,
  output logic [CNT_WIDTH-1:0] cnt_nx,
  output logic sat_nx
);
  import range_tracker_pkg::*;
  logic [WIDTH-1:0] min_q, max_q, min_b, max_b;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_b;
  logic sat_q, sat_b, first;
  always_comb begin
    min_b = clear ? '0 : min_q;
    max_b = clear ? '0 : max_q;
    cnt_b = clear ? '0 : cnt_q;
    sat_b = clear ? 1'b0 : sat_q;
    first = cnt_b == '0;
    min_nx = accept && (first || less_than(signed_mode, sample[WIDTH-1], min_b[WIDTH-1], sample < min_b)) ? sample : min_b;
    max_nx = accept && (first || less_than(signed_mode, max_b[WIDTH-1], sample[WIDTH-1], max_b < sample)) ? sample : max_b;
    cnt_nx = accept && cnt_b != '1 ? cnt_b + 1'b1 : cnt_b;
    sat_nx = sat_b | (&cnt_nx);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      min_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      min_q <= min_nx;
      max_q <= max_nx;
      cnt_q <= cnt_nx;
      sat_q <= sat_nx;
    end
endmodule

// File: rtl/range_tracker_multi.sv
// range_tracker_multi: per-channel min/max/range/count over a go/finish window
// Ports: clock, reset_n (async low), bus (slave modport of
// range_tracker_multi_if: samples, go/finish/signed_mode in; busy, done pulse,
// latched results, count_sat and err_code out).
module range_tracker_multi #(
  parameter int WIDTH = 16,
  parameter int CHANNELS = 4,
  parameter int CNT_WIDTH = 8
) (
  input logic clock,
  input logic reset_n,
  range_tracker_multi_if.slave bus
);
  import range_tracker_pkg::*;
  state_t state_q, state_d;
  err_t err_q, err_d;
  logic mode_q, open, close, acc_en, empty, done_r;
  logic [CHANNELS-1:0][WIDTH-1:0] mn, mx, min_r, max_r, rng_r;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cn, cnt_r;
  logic [CHANNELS-1:0] st, sat_r;
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    range_channel #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_ch (
      .clock(clock),
      .reset_n(reset_n),
      .clear(open),
      .accept(acc_en & bus.data_valid[k]),
      .signed_mode(mode_q),
      .sample(bus.data_in[k*WIDTH +: WIDTH]),
      .min_nx(mn[k]),
      .max_nx(mx[k]),
      .cnt_nx(cn[k]),
      .sat_nx(st[k])
    );
  end
  // samples are taken while the window opens, runs or closes; an abort
  // (go with finish) takes nothing
  always_comb begin
    open = bus.go & ~bus.finish;
    close = ~bus.go & bus.finish & (state_q == ACTIVE);
    acc_en = bus.go ? ~bus.finish : state_q == ACTIVE;
    empty = 1'b0;
    for (int i = 0; i < CHANNELS; i++) empty = empty | (cn[i] == '0);
    state_d = open ? ACTIVE : bus.finish ? IDLE : state_q;
    err_d = open ? ERR_NONE : bus.go ? ERR_GO_FINISH : !bus.finish ? err_q :
            state_q == IDLE ? ERR_FINISH_IDLE : empty ? ERR_EMPTY : err_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      err_q <= ERR_NONE;
      mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q <= err_d;
      if (open) mode_q <= bus.signed_mode;
    end
  // an empty channel's working stats are still at their cleared zero, so
  // latching them directly yields the all-zero result
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      done_r <= 1'b0;
      min_r <= '0;
      max_r <= '0;
      rng_r <= '0;
      cnt_r <= '0;
      sat_r <= '0;
    end else begin
      done_r <= close;
      if (close) begin
        min_r <= mn;
        max_r <= mx;
        cnt_r <= cn;
        sat_r <= st;
        for (int i = 0; i < CHANNELS; i++) rng_r[i] <= mx[i] - mn[i];
      end
    end
  assign bus.busy = state_q == ACTIVE;
  assign bus.done = done_r;
  assign bus.min_out = min_r;
  assign bus.max_out = max_r;
  assign bus.range_out = rng_r;
  assign bus.count_out = cnt_r;
  assign bus.count_sat = sat_r;
  assign bus.err_code = err_q;
endmodule

// File: tb/tb_range_tracker_multi.sv
// tb_range_tracker_multi: scoreboard bench with a sample-list reference model
module tb_range_tracker_multi;
  localparam int W = 16;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int CMAX = 255;
  typedef struct {
    logic [CH*W-1:0] mn, mx, rg;
    logic [CH*CW-1:0] cn;
    logic [CH-1:0] st;
  } res_t;
  typedef struct {
    bit busy, done, clr;
    logic [1:0] err;
  } st_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  range_tracker_multi_if #(.WIDTH(W), .CHANNELS(CH), .CNT_WIDTH(CW)) bus ();
  range_tracker_multi #(.WIDTH(W), .CHANNELS(CH), .CNT_WIDTH(CW)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  res_t rq[$];
  st_t sq[$];
  res_t held;
  int errors = 0;
  int checks = 0;
  int samples[CH][$];
  bit m_active = 1'b0;
  bit m_mode = 1'b0;
  logic [1:0] m_err = 2'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CH*W-1:0] pk(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [CH*W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  // results straight from the recorded sample lists: min/max over the values
  // read as integers in the window's mode
  function automatic res_t close_window();
    res_t r;
    r = '{mn: '0, mx: '0, rg: '0, cn: '0, st: '0};
    for (int k = 0; k < CH; k++) begin
      int n, lo, hi, v, d, c;
      n = samples[k].size();
      lo = 0;
      hi = 0;
      for (int i = 0; i < n; i++) begin
        v = samples[k][i];
        if (m_mode && v >= 32768) v = v - 65536;
        if (i == 0 || v < lo) lo = v;
        if (i == 0 || v > hi) hi = v;
      end
      d = hi - lo;
      c = n > CMAX ? CMAX : n;
      r.mn[k*W +: W] = lo[W-1:0];
      r.mx[k*W +: W] = hi[W-1:0];
      r.rg[k*W +: W] = d[W-1:0];
      r.cn[k*CW +: CW] = c[CW-1:0];
      r.st[k] = n >= CMAX;
    end
    return r;
  endfunction

  task automatic step(input bit g, input bit f, input bit sm, input logic [CH-1:0] v, input logic [CH*W-1:0] d);
    st_t s;
    bit acc, emp;
    s = '{busy: 1'b0, done: 1'b0, clr: 1'b0, err: 2'd0};
    @(negedge clock);
    bus.go = g;
    bus.finish = f;
    bus.signed_mode = sm;
    bus.data_valid = v;
    bus.data_in = d;
    acc = (g && !f) || (m_active && !(g && f));
    if (g && !f) begin
      for (int k = 0; k < CH; k++) samples[k].delete();
      m_mode = sm;
      m_err = 2'd0;
    end
    if (acc)
      for (int k = 0; k < CH; k++)
        if (v[k]) samples[k].push_back(int'(d[k*W +: W]));
    if (g && f) begin
      m_active = 1'b0;
      m_err = 2'd1;
    end else if (g) m_active = 1'b1;
    else if (f && !m_active) m_err = 2'd2;
    else if (f) begin
      rq.push_back(close_window());
      s.done = 1'b1;
      m_active = 1'b0;
      emp = 1'b0;
      for (int k = 0; k < CH; k++) if (samples[k].size() == 0) emp = 1'b1;
      if (emp) m_err = 2'd3;
    end
    s.busy = m_active;
    s.err = m_err;
    sq.push_back(s);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.go = 1'b0;
    bus.finish = 1'b0;
    bus.data_valid = '0;
    reset_n = 1'b0;
    m_active = 1'b0;
    m_err = 2'd0;
    m_mode = 1'b0;
    for (int k = 0; k < CH; k++) samples[k].delete();
    sq.push_back('{busy: 1'b0, done: 1'b0, clr: 1'b1, err: 2'd0});
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_min", bus.min_out, 64'd0);
    chk("rst_max", bus.max_out, 64'd0);
    chk("rst_count", 64'(bus.count_out), 64'd0);
    chk("rst_err", 64'(bus.err_code), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    sq.push_back('{busy: 1'b0, done: 1'b0, clr: 1'b0, err: 2'd0});
  endtask

  // monitor: one status entry per driven cycle; a done pops the next result
  initial begin
    held = '{mn: '0, mx: '0, rg: '0, cn: '0, st: '0};
    forever begin
      @(posedge clock);
      #1;
      if (sq.size() > 0) begin
        st_t s;
        s = sq.pop_front();
        if (s.clr) held = '{mn: '0, mx: '0, rg: '0, cn: '0, st: '0};
        chk("busy", 64'(bus.busy), 64'(s.busy));
        chk("done", 64'(bus.done), 64'(s.done));
        chk("err_code", 64'(bus.err_code), 64'(s.err));
        if (bus.done) begin
          if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_no_result: done=1 with no expected result at %0t", $time);
          end else held = rq.pop_front();
        end
        chk("min_out", bus.min_out, held.mn);
        chk("max_out", bus.max_out, held.mx);
        chk("range_out", bus.range_out, held.rg);
        chk("count_out", 64'(bus.count_out), 64'(held.cn));
        chk("count_sat", 64'(bus.count_sat), 64'(held.st));
      end
    end
  end

  initial begin
    bus.go = 1'b0;
    bus.finish = 1'b0;
    bus.signed_mode = 1'b0;
    bus.data_valid = '0;
    bus.data_in = '0;
    do_reset();
    idle();
    // unsigned ch0 10,3,250,7
    step(1, 0, 0, 4'hF, pk(16'd10, 16'($urandom), 16'($urandom), 16'($urandom)));
    step(0, 0, 1, 4'h1, pk(16'd3, 0, 0, 0));
    step(0, 0, 1, 4'h1, pk(16'd250, 0, 0, 0));
    step(0, 0, 1, 4'h1, pk(16'd7, 0, 0, 0));
    step(0, 1, 0, 4'h0, '0);
    idle();
    chk("t1_min0", 64'(bus.min_out[0 +: W]), 64'd3);
    chk("t1_max0", 64'(bus.max_out[0 +: W]), 64'd250);
    chk("t1_rng0", 64'(bus.range_out[0 +: W]), 64'd247);
    chk("t1_cnt0", 64'(bus.count_out[0 +: CW]), 64'd4);
    chk("t1_err", 64'(bus.err_code), 64'd0);
    // signed ch1 -10,20,0
    step(1, 0, 1, 4'hF, pk(16'($urandom), 16'hFFF6, 16'($urandom), 16'($urandom)));
    step(0, 0, 0, 4'h2, pk(0, 16'h0014, 0, 0));
    step(0, 0, 0, 4'h2, pk(0, 16'h0000, 0, 0));
    step(0, 1, 0, 4'h0, '0);
    idle();
    chk("t2s_min1", 64'(bus.min_out[W +: W]), 64'hFFF6);
    chk("t2s_max1", 64'(bus.max_out[W +: W]), 64'h0014);
    chk("t2s_rng1", 64'(bus.range_out[W +: W]), 64'd30);
    // same data unsigned
    step(1, 0, 0, 4'hF, pk(16'($urandom), 16'hFFF6, 16'($urandom), 16'($urandom)));
    step(0, 0, 1, 4'h2, pk(0, 16'h0014, 0, 0));
    step(0, 0, 1, 4'h2, pk(0, 16'h0000, 0, 0));
    step(0, 1, 1, 4'h0, '0);
    idle();
    chk("t2u_min1", 64'(bus.min_out[W +: W]), 64'h0);
    chk("t2u_max1", 64'(bus.max_out[W +: W]), 64'hFFF6);
    chk("t2u_rng1", 64'(bus.range_out[W +: W]), 64'hFFF6);
    // go&finish in IDLE, then abort in ACTIVE
    step(1, 1, 0, 4'hF, rnd());
    idle();
    chk("t3_err_idle", 64'(bus.err_code), 64'd1);
    step(1, 0, 0, 4'hF, rnd());
    step(0, 0, 0, 4'hF, rnd());
    step(1, 1, 0, 4'hF, rnd());
    idle();
    chk("t3_err_abort", 64'(bus.err_code), 64'd1);
    chk("t3_keep_max1", 64'(bus.max_out[W +: W]), 64'hFFF6);
    // finish in IDLE, then window with ch2 silent
    step(0, 1, 0, 4'hF, rnd());
    idle();
    chk("t4_err_fin", 64'(bus.err_code), 64'd2);
    step(1, 0, 0, 4'hB, rnd());
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'hB, rnd());
    step(0, 1, 0, 4'hB, rnd());
    idle();
    chk("t4_err_empty", 64'(bus.err_code), 64'd3);
    chk("t4_min2", 64'(bus.min_out[2*W +: W]), 64'd0);
    chk("t4_max2", 64'(bus.max_out[2*W +: W]), 64'd0);
    chk("t4_cnt2", 64'(bus.count_out[2*CW +: CW]), 64'd0);
    // 300 samples on ch3, last one 999 on the finish cycle
    step(1, 0, 0, 4'h8, pk(0, 0, 0, 16'($urandom_range(0, 998))));
    for (int i = 0; i < 298; i++) step(0, 0, 0, 4'h8, pk(0, 0, 0, 16'($urandom_range(0, 998))));
    step(0, 1, 0, 4'h8, pk(0, 0, 0, 16'd999));
    idle();
    chk("t5_cnt3", 64'(bus.count_out[3*CW +: CW]), 64'd255);
    chk("t5_sat3", 64'(bus.count_sat[3]), 64'd1);
    chk("t5_max3", 64'(bus.max_out[3*W +: W]), 64'd999);
    // reset mid-window after 5 samples, then a normal window
    step(1, 0, 0, 4'hF, rnd());
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'hF, rnd());
    do_reset();
    step(1, 0, 1, 4'hF, rnd());
    step(0, 0, 0, 4'hF, rnd());
    step(0, 1, 0, 4'hF, rnd());
    idle();
    // random windows with restarts and stray error commands
    for (int w = 0; w < 40; w++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) step(1, 1, 1'($urandom), 4'($urandom), rnd());
      else if (r == 1) step(0, 1, 1'($urandom), 4'($urandom), rnd());
      step(1, 0, 1'($urandom), 4'($urandom), rnd());
      repeat ($urandom_range(0, 8)) step($urandom_range(0, 7) == 0, 0, 1'($urandom), 4'($urandom), rnd());
      if ($urandom_range(0, 9) == 0) step(1, 1, 1'($urandom), 4'($urandom), rnd());
      else step(0, 1, 1'($urandom), 4'($urandom), rnd());
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
    idle();
    @(posedge clock);
    #2;
    chk("pending_results", 64'(rq.size()), 64'd0);
    chk("pending_status", 64'(sq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
